// File: rtl/reg_sys_ctrl_pkg.sv
// Shared constants, state encoding and address helpers for the register-file command sequencer.
package reg_sys_ctrl_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned BURST_MAX = 8;

  localparam logic [DATA_W-1:0] CMD_WR   = 8'hAA;
  localparam logic [DATA_W-1:0] CMD_RD   = 8'hBB;
  localparam logic [DATA_W-1:0] CMD_BRD  = 8'hCC;
  localparam logic [DATA_W-1:0] ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_GET_CNT  = 3'd3,
    ST_WR       = 3'd4,
    ST_RD_REQ   = 3'd5,
    ST_RD_WAIT  = 3'd6,
    ST_SEND     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    OP_WR  = 2'd0,
    OP_RD  = 2'd1,
    OP_BRD = 2'd2
  } op_e;

  // Address is implemented in the register file.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS);
  endfunction

  // Next burst address, wrapping within the implemented register range.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return ADDR_W'((32'(a) + 32'd1) % NUM_REGS);
  endfunction

endpackage

// File: rtl/reg_sys_ctrl.sv
// Byte-frame command sequencer: decodes UART RX frames into register-file
// write/read strobes and forwards read results to the UART TX FIFO.
module reg_sys_ctrl
  import reg_sys_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic              WrEN,
  output logic              RdEN,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_VLD,
  output logic [DATA_W-1:0] TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              FIFO_FULL,
  output logic              BUSY,
  output logic              CMD_ERR
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                wren_q, wren_d;
  logic                rden_q, rden_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                tx_vld_c;

  // Next-state, datapath and registered-strobe decode.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    err_d    = 1'b0;
    tx_vld_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_WR: begin
              op_d    = OP_WR;
              state_d = ST_GET_ADDR;
            end
            CMD_RD: begin
              op_d    = OP_RD;
              state_d = ST_GET_ADDR;
            end
            CMD_BRD: begin
              op_d    = OP_BRD;
              state_d = ST_GET_ADDR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_GET_ADDR: begin
        if (RX_D_VLD) begin
          addr_d = RX_P_DATA[ADDR_W-1:0];
          case (op_q)
            OP_WR:   state_d = ST_GET_DATA;
            OP_RD: begin
              cnt_d   = CNT_W'(1);
              state_d = ST_RD_REQ;
            end
            default: state_d = ST_GET_CNT;
          endcase
        end
      end

      ST_GET_DATA: begin
        if (RX_D_VLD) begin
          data_d  = RX_P_DATA;
          state_d = ST_WR;
        end
      end

      ST_GET_CNT: begin
        if (RX_D_VLD) begin
          cnt_d   = (RX_P_DATA[CNT_W-1:0] == '0) ? CNT_W'(BURST_MAX)
                                                 : RX_P_DATA[CNT_W-1:0];
          state_d = ST_RD_REQ;
        end
      end

      ST_WR: begin
        err_d   = RX_D_VLD;
        state_d = ST_IDLE;
      end

      ST_RD_REQ: begin
        err_d = RX_D_VLD;
        if (addr_ok(addr_q)) begin
          state_d = ST_RD_WAIT;
        end else begin
          tx_d    = ERR_BYTE;
          state_d = ST_SEND;
        end
      end

      ST_RD_WAIT: begin
        err_d = RX_D_VLD;
        if (RdData_VLD) begin
          tx_d    = RdData;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        err_d    = RX_D_VLD;
        tx_vld_c = !FIFO_FULL;
        if (!FIFO_FULL) begin
          cnt_d   = cnt_q - CNT_W'(1);
          addr_d  = addr_inc(addr_q);
          state_d = (cnt_q == CNT_W'(1)) ? ST_IDLE : ST_RD_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered, so they are decided on entry to the strobing state.
    wren_d = (state_d == ST_WR) && addr_ok(addr_d);
    rden_d = (state_d == ST_RD_REQ) && addr_ok(addr_d);
    if ((state_d == ST_WR) && !addr_ok(addr_d)) begin
      err_d = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      op_q    <= OP_WR;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign WrEN      = wren_q;
  assign RdEN      = rden_q;
  assign Address   = addr_q;
  assign WrData    = data_q;
  assign TX_P_DATA = tx_q;
  assign TX_D_VLD  = tx_vld_c;
  assign BUSY      = busy_q;
  assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_reg_sys_ctrl.sv
// Self-checking bench for reg_sys_ctrl: frame-level reference model with
// event scoreboards, directed latency checks and randomized frames.
module tb_reg_sys_ctrl;

  logic       clk;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       WrEN;
  logic       RdEN;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_VLD;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       FIFO_FULL;
  logic       BUSY;
  logic       CMD_ERR;

  int checks;
  int failures;
  int cyc;

  // Reference model state.
  logic [7:0]  model_mem [8];
  logic [11:0] exp_wr [$];
  logic [3:0]  exp_rd [$];
  logic [7:0]  exp_tx [$];
  int          exp_err;
  int          obs_err;

  // Observed-event logs used by the directed latency checks.
  logic [11:0] wr_log [$];
  int          wr_cyc [$];
  logic [3:0]  rd_log [$];
  int          rd_cyc [$];
  logic [7:0]  tx_log [$];
  int          tx_cyc [$];
  int          err_cyc [$];

  logic        bp_rand;
  logic        rf_load;
  logic [7:0]  rf_init [8];
  logic [7:0]  rf [8];

  reg_sys_ctrl dut (
    .clk        (clk),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .WrEN       (WrEN),
    .RdEN       (RdEN),
    .Address    (Address),
    .WrData     (WrData),
    .RdData     (RdData),
    .RdData_VLD (RdData_VLD),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .FIFO_FULL  (FIFO_FULL),
    .BUSY       (BUSY),
    .CMD_ERR    (CMD_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file stand-in: data returned the cycle after RdEN.
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (WrEN && (Address < 4'd8)) begin
      rf[Address[2:0]] <= WrData;
    end
    RdData_VLD <= RdEN;
    if (RdEN && (Address < 4'd8)) RdData <= rf[Address[2:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Compare process: checks every DUT event against the model queues.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (RST) begin
        chk("strobe_excl", 32'(WrEN & RdEN), 32'd0);
        if (FIFO_FULL) chk("txvld_while_full", 32'(TX_D_VLD), 32'd0);
        if (WrEN) begin
          wr_log.push_back({Address, WrData});
          wr_cyc.push_back(cyc);
          if (exp_wr.size() == 0) fail_evt("wr_unexpected", 32'({Address, WrData}));
          else chk("wr_event", 32'({Address, WrData}), 32'(exp_wr.pop_front()));
        end
        if (RdEN) begin
          rd_log.push_back(Address);
          rd_cyc.push_back(cyc);
          if (exp_rd.size() == 0) fail_evt("rd_unexpected", 32'(Address));
          else chk("rd_event", 32'(Address), 32'(exp_rd.pop_front()));
        end
        if (TX_D_VLD) begin
          tx_log.push_back(TX_P_DATA);
          tx_cyc.push_back(cyc);
          if (exp_tx.size() == 0) fail_evt("tx_unexpected", 32'(TX_P_DATA));
          else chk("tx_byte", 32'(TX_P_DATA), 32'(exp_tx.pop_front()));
        end
        if (CMD_ERR) begin
          obs_err++;
          err_cyc.push_back(cyc);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_rand) FIFO_FULL = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b, output int t);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    t = cyc;
    tick();
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'h00;
  endtask

  // Sends n frame bytes with random idle gaps; t is the cycle of the last byte.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n, input int maxgap, output int t);
    logic [7:0] fb [3];
    fb[0] = b0;
    fb[1] = b1;
    fb[2] = b2;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, maxgap)) tick();
      send_byte(fb[i], t);
    end
  endtask

  task automatic inject(input int maxk);
    int t;
    repeat ($urandom_range(0, maxk)) tick();
    send_byte(8'($urandom), t);
    exp_err++;
  endtask

  task automatic model_write(input logic [7:0] ab, input logic [7:0] d);
    logic [3:0] a;
    a = ab[3:0];
    if (a < 4'd8) begin
      exp_wr.push_back({a, d});
      model_mem[a[2:0]] = d;
    end else begin
      exp_err++;
    end
  endtask

  task automatic model_read(input logic [7:0] ab, input int n);
    int a;
    a = int'(ab[3:0]);
    for (int i = 0; i < n; i++) begin
      if (a < 8) begin
        exp_rd.push_back(4'(a));
        exp_tx.push_back(model_mem[a]);
      end else begin
        exp_tx.push_back(8'hEE);
      end
      a = (a + 1) % 8;
    end
  endtask

  function automatic int burst_len(input logic [7:0] c);
    return (c[3:0] == 4'd0) ? 8 : int'(c[3:0]);
  endfunction

  task automatic begin_frame();
    exp_wr.delete();
    exp_rd.delete();
    exp_tx.delete();
    exp_err = 0;
    obs_err = 0;
    wr_log.delete(); wr_cyc.delete();
    rd_log.delete(); rd_cyc.delete();
    tx_log.delete(); tx_cyc.delete();
    err_cyc.delete();
  endtask

  task automatic finish_frame();
    int n;
    n = 0;
    while (BUSY && (n < 3000)) begin
      tick();
      n++;
    end
    if (BUSY) fail_evt("busy_timeout", 32'(n));
    repeat (3) tick();
    chk("pending_wr", 32'(exp_wr.size()), 32'd0);
    chk("pending_rd", 32'(exp_rd.size()), 32'd0);
    chk("pending_tx", 32'(exp_tx.size()), 32'd0);
    chk("cmd_err_count", 32'(obs_err), 32'(exp_err));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wren"},   32'(WrEN),      32'd0);
    chk({tag, "_rden"},   32'(RdEN),      32'd0);
    chk({tag, "_txvld"},  32'(TX_D_VLD),  32'd0);
    chk({tag, "_cmderr"}, 32'(CMD_ERR),   32'd0);
    chk({tag, "_busy"},   32'(BUSY),      32'd0);
    chk({tag, "_addr"},   32'(Address),   32'd0);
    chk({tag, "_wrdata"}, 32'(WrData),    32'd0);
    chk({tag, "_txdata"}, 32'(TX_P_DATA), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    int         t2;
    int         kind;
    logic [7:0] ab;
    logic [7:0] d;
    logic [7:0] c;
    logic [7:0] b;
    logic [3:0] exp_addr [4];

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    exp_err   = 0;
    obs_err   = 0;
    bp_rand   = 1'b0;
    RST       = 1'b0;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    FIFO_FULL = 1'b0;
    rf_load   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rf_init[i]   = 8'($urandom);
      model_mem[i] = rf_init[i];
    end
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) tick();
    check_zero("reset");
    rf_load = 1'b0;
    RST = 1'b1;
    repeat (2) tick();
    check_zero("post_reset");

    // Write AA 02 5A: single WrEN one cycle after the data byte.
    begin_frame();
    model_write(8'h02, 8'h5A);
    send_frame(8'hAA, 8'h02, 8'h5A, 3, 0, t);
    finish_frame();
    chk("wr_count", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) begin
      chk("wr_latency", 32'(wr_cyc[0]), 32'(t + 1));
      chk("wr_addr_data", 32'(wr_log[0]), 32'h25A);
    end

    // Read BB 02: RdEN at T+1, TX byte 5A at T+3.
    begin_frame();
    model_read(8'h02, 1);
    send_frame(8'hBB, 8'h02, 8'h00, 2, 0, t);
    finish_frame();
    chk("rd_count", 32'(rd_cyc.size()), 32'd1);
    chk("tx_count", 32'(tx_log.size()), 32'd1);
    if (rd_cyc.size() == 1) chk("rd_latency", 32'(rd_cyc[0]), 32'(t + 1));
    if (tx_log.size() == 1) begin
      chk("tx_latency", 32'(tx_cyc[0]), 32'(t + 3));
      chk("tx_readback", 32'(tx_log[0]), 32'h5A);
    end

    // Burst CC 06 03: addresses 6, 7, 0 at 3 cycles per byte.
    begin_frame();
    model_read(8'h06, 3);
    send_frame(8'hCC, 8'h06, 8'h03, 3, 0, t);
    while (cyc < t + 9) tick();
    chk("burst_busy_last", 32'(BUSY), 32'd1);
    tick();
    chk("burst_busy_fall", 32'(BUSY), 32'd0);
    finish_frame();
    exp_addr[0] = 4'd6;
    exp_addr[1] = 4'd7;
    exp_addr[2] = 4'd0;
    chk("burst_rd_count", 32'(rd_log.size()), 32'd3);
    chk("burst_tx_count", 32'(tx_cyc.size()), 32'd3);
    if ((rd_log.size() == 3) && (tx_cyc.size() == 3)) begin
      for (int i = 0; i < 3; i++) begin
        chk("burst_rd_addr", 32'(rd_log[i]), 32'(exp_addr[i]));
        chk("burst_rd_cycle", 32'(rd_cyc[i]), 32'(t + 1 + 3 * i));
        chk("burst_tx_cycle", 32'(tx_cyc[i]), 32'(t + 3 + 3 * i));
      end
    end

    // Out-of-range read BB 09: no RdEN, TX byte EE.
    begin_frame();
    model_read(8'h09, 1);
    send_frame(8'hBB, 8'h09, 8'h00, 2, 0, t);
    finish_frame();
    chk("oor_rd_count", 32'(rd_log.size()), 32'd0);
    chk("oor_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) chk("oor_tx_byte", 32'(tx_log[0]), 32'hEE);

    // Out-of-range write AA 0C 11: no WrEN, one CMD_ERR.
    begin_frame();
    model_write(8'h0C, 8'h11);
    send_frame(8'hAA, 8'h0C, 8'h11, 3, 0, t);
    finish_frame();
    chk("oor_wr_count", 32'(wr_log.size()), 32'd0);
    chk("oor_wr_err", 32'(err_cyc.size()), 32'd1);

    // Backpressure: FIFO_FULL held for the first 10 SEND cycles.
    begin_frame();
    model_write(8'h03, 8'hC3);
    send_frame(8'hAA, 8'h03, 8'hC3, 3, 0, t);
    finish_frame();
    begin_frame();
    model_read(8'h03, 1);
    FIFO_FULL = 1'b1;
    send_frame(8'hBB, 8'h03, 8'h00, 2, 0, t);
    while (cyc < t + 3) tick();
    while (cyc <= t + 12) begin
      chk("bp_txvld_low", 32'(TX_D_VLD), 32'd0);
      chk("bp_txdata_hold", 32'(TX_P_DATA), 32'hC3);
      tick();
    end
    FIFO_FULL = 1'b0;
    #1;
    chk("bp_release_vld", 32'(TX_D_VLD), 32'd1);
    finish_frame();
    chk("bp_tx_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() == 1) begin
      chk("bp_tx_cycle", 32'(tx_cyc[0]), 32'(t + 13));
      chk("bp_tx_byte", 32'(tx_log[0]), 32'hC3);
    end

    // Bad opcode 3C in IDLE.
    begin_frame();
    exp_err++;
    send_frame(8'h3C, 8'h00, 8'h00, 1, 0, t);
    chk("bad_op_busy", 32'(BUSY), 32'd0);
    finish_frame();
    chk("bad_op_err_count", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() == 1) chk("bad_op_err_cycle", 32'(err_cyc[0]), 32'(t + 1));

    // Byte arriving during burst SEND is dropped; burst completes.
    begin_frame();
    model_read(8'h00, 4);
    send_frame(8'hCC, 8'h00, 8'h04, 3, 0, t);
    tick();
    tick();
    send_byte(8'hAA, t2);
    exp_err++;
    chk("inject_in_send", 32'(t2), 32'(t + 3));
    finish_frame();
    chk("inject_err_count", 32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() == 1) chk("inject_err_cycle", 32'(err_cyc[0]), 32'(t + 4));
    chk("inject_tx_count", 32'(tx_log.size()), 32'd4);
    chk("inject_rd_count", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      exp_addr[0] = 4'd0;
      exp_addr[1] = 4'd1;
      exp_addr[2] = 4'd2;
      exp_addr[3] = 4'd3;
      for (int i = 0; i < 4; i++) chk("inject_rd_addr", 32'(rd_log[i]), 32'(exp_addr[i]));
    end

    // Reset while waiting for the data byte of AA 01 77.
    begin_frame();
    send_frame(8'hAA, 8'h01, 8'h00, 2, 0, t);
    RST = 1'b0;
    #1;
    check_zero("abort");
    tick();
    tick();
    check_zero("abort_hold");
    RST = 1'b1;
    repeat (3) tick();
    chk("abort_no_wr", 32'(wr_log.size()), 32'd0);
    begin_frame();
    model_write(8'h01, 8'h77);
    send_frame(8'hAA, 8'h01, 8'h77, 3, 0, t);
    finish_frame();
    chk("abort_next_wr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) chk("abort_next_data", 32'(wr_log[0]), 32'h177);

    // Randomized frames with random backpressure and dropped busy-time bytes.
    bp_rand = 1'b1;
    for (int f = 0; f < 250; f++) begin
      kind = int'($urandom_range(0, 9));
      begin_frame();
      if (kind <= 2) begin
        ab = {4'($urandom), 4'($urandom_range(0, 11))};
        d  = 8'($urandom);
        model_write(ab, d);
        send_frame(8'hAA, ab, d, 3, 2, t);
      end else if (kind <= 5) begin
        ab = {4'($urandom), 4'($urandom_range(0, 11))};
        model_read(ab, 1);
        send_frame(8'hBB, ab, 8'h00, 2, 2, t);
        if ($urandom_range(0, 2) == 0) inject((ab[3:0] < 4'd8) ? 2 : 1);
      end else if (kind <= 8) begin
        ab = {4'($urandom), 4'($urandom_range(0, 7))};
        c  = {4'($urandom), 4'($urandom_range(0, 8))};
        model_read(ab, burst_len(c));
        send_frame(8'hCC, ab, c, 3, 2, t);
        if ($urandom_range(0, 2) == 0) inject(2);
      end else begin
        b = 8'($urandom);
        while ((b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC)) b = 8'($urandom);
        exp_err++;
        send_frame(b, 8'h00, 8'h00, 1, 2, t);
      end
      finish_frame();
    end
    bp_rand   = 1'b0;
    FIFO_FULL = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_sys_ctrl.md
# reg_sys_ctrl

Command sequencer for the 8-entry system register file. It takes byte frames from the UART receiver and turns them into single-cycle write and read strobes on the register file. Read results are forwarded to the UART TX FIFO. It sits between the RX deserializer, the register file and the TX FIFO, and is the only master of the register file port.

## Interface
- `CMD_WR`, 8'hAA: write command opcode
- `CMD_RD`, 8'hBB: single read opcode
- `CMD_BRD`, 8'hCC: burst read opcode
- `ERR_BYTE`, 8'hEE: byte sent for an out-of-range read
- `NUM_REGS`, 8: implemented register count (address 0..NUM_REGS-1)
- `clk` in 1: system clock, all logic on rising edge
- `RST` in 1: asynchronous, active-low reset
- `RX_P_DATA` in 8: received byte
- `RX_D_VLD` in 1: one-cycle pulse, RX_P_DATA valid
- `WrEN` out 1: register file write strobe
- `RdEN` out 1: register file read strobe
- `Address` out 4: register file address
- `WrData` out 8: register file write data
- `RdData` in 8: register file read data
- `RdData_VLD` in 1: register file read valid
- `TX_P_DATA` out 8: byte to TX FIFO
- `TX_D_VLD` out 1: TX FIFO write strobe
- `FIFO_FULL` in 1: TX FIFO cannot accept
- `BUSY` out 1: high in any state other than IDLE
- `CMD_ERR` out 1: one-cycle pulse, byte rejected

## Operation
- **Frames:**
  - Write: `AA addr data`.
  - Read: `BB addr`.
  - Burst read: `CC addr cnt`. cnt is 1..8 and 0 means 8. Addresses increment modulo NUM_REGS, so 7 wraps to 0.
- **States:** IDLE, GET_ADDR, GET_DATA, GET_CNT, WR, RD_REQ, RD_WAIT, SEND.
- **IDLE:**
  - On RX_D_VLD, opcode AA/BB/CC is latched and the FSM moves to GET_ADDR.
  - Any other byte pulses CMD_ERR and the FSM stays in IDLE.
- **GET_ADDR:** on RX_D_VLD, latch addr[3:0], ignore addr[7:4].
  - AA goes to GET_DATA.
  - BB loads remaining count 1 and goes to RD_REQ.
  - CC goes to GET_CNT.
- **GET_DATA:** on RX_D_VLD, latch data and go to WR.
- **GET_CNT:** on RX_D_VLD, load remaining count (4-bit, 0 becomes 8) and go to RD_REQ.
- **WR:**
  - WrEN=1 for exactly one cycle, with Address and WrData valid.
  - Then return to IDLE.
  - Address >= NUM_REGS: WrEN stays 0, CMD_ERR pulses.
- **RD_REQ:**
  - RdEN=1 for exactly one cycle, then RD_WAIT.
  - Address >= NUM_REGS: skip RdEN, load ERR_BYTE into the TX holding register and go to SEND.
- **RD_WAIT:** when RdData_VLD=1, capture RdData into the TX holding register and go to SEND.
- **SEND:**
  - TX_D_VLD = !FIFO_FULL.
  - On the accepting cycle, decrement the count and advance Address (mod NUM_REGS).
  - If count becomes 0, go to IDLE. Otherwise go to RD_REQ.
- **Busy-time bytes:** RX_D_VLD while in WR, RD_REQ, RD_WAIT or SEND drops the byte and pulses CMD_ERR. The current frame continues unaffected.
- **Strobe exclusivity:** WrEN and RdEN are never high in the same cycle.

## Timing
- **Reset (RST=0):** state IDLE. WrEN, RdEN, TX_D_VLD, CMD_ERR, BUSY are 0; Address, WrData, TX_P_DATA are 0; count is 0.
- **Reset mid-frame:** a reset in the middle of a frame aborts it with no strobe emitted.
- **Write latency:** last frame byte accepted in cycle T gives WrEN high in T+1.
- **Single read:**
  - addr byte in T gives RdEN high in T+1.
  - RdData_VLD is expected in T+2.
  - TX_D_VLD rises in T+3 when FIFO_FULL=0.
- **FIFO_FULL backpressure:** SEND holds while FIFO_FULL=1. TX_P_DATA stays stable and TX_D_VLD stays 0, with no limit on the wait.
- **Burst throughput:** 3 cycles per byte with no backpressure.
- **RD_WAIT:** has no timeout, because the register file always returns RdData_VLD the cycle after RdEN.
- **CMD_ERR:** registered, high in the cycle after the offending event.
- **Other outputs:** WrEN, RdEN and BUSY are registered. TX_D_VLD is the only output with a combinational path, from FIFO_FULL.

## Structure
- **Package `reg_sys_ctrl_pkg`:**
  - state enum (3-bit encoding)
  - CMD_WR, CMD_RD, CMD_BRD and ERR_BYTE defaults
  - NUM_REGS default
- **Single module:** one FSM plus address, data, count and TX-hold registers, with no sub-module needed.
- **Top-level wiring:** Address, WrData, WrEN and RdEN connect directly to the register file ports of the same names.

## Test plan
- **Write:** after reset, send AA 02 5A → one WrEN pulse with Address=2, WrData=5A. A following BB 02 → TX_P_DATA=5A with one TX_D_VLD pulse, 3 cycles after the addr byte.
- **Burst wrap:** send CC 06 03 → reads at addresses 6, 7, 0, then three TX bytes equal to the register values, then BUSY falls.
- **Out of range:** BB 09 → no RdEN, TX byte EE. AA 0C 11 → no WrEN and one CMD_ERR pulse.
- **Backpressure:** hold FIFO_FULL=1 for 10 cycles during SEND → TX_D_VLD stays 0 and TX_P_DATA is stable. The byte is sent on the first cycle with FIFO_FULL=0.
- **Bad input:** byte 3C in IDLE → CMD_ERR pulse and FSM stays in IDLE. A byte arriving during burst SEND → CMD_ERR pulse and the burst completes intact.
- **Reset abort:** assert RST in GET_DATA of AA 01 77 → no WrEN, outputs return to 0, and the next frame is decoded normally.
